// File: rtl/sram_arbiter_if.sv
// Requester-side and controller-side signal bundle for sram_arbiter.
// The arbiter uses the slave view; the requesters/controller model use the master view.
interface sram_arbiter_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_done;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_done;
    logic [DATA_W-1:0] b_rdata;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_write;
    logic              mem_write;
    logic              mem_read;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_data_read;

    logic              busy;
    logic              timeout_err;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  mem_ready, mem_data_read,
        output a_done, a_rdata, b_done, b_rdata,
        output mem_address, mem_data_write, mem_write, mem_read,
        output busy, timeout_err
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output mem_ready, mem_data_read,
        input  a_done, a_rdata, b_done, b_rdata,
        input  mem_address, mem_data_write, mem_write, mem_read,
        input  busy, timeout_err
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of a single SRAM controller: serialises whole
// transactions, issues one-cycle strobes, returns one-cycle done pulses, watchdog on WAIT.
module sram_arbiter #(
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic           clk,
    input  logic           reset,
    sram_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_HOLD,
        S_WAIT,
        S_RESP
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

    state_t            r_state;
    port_t             r_owner;
    port_t             r_last;
    logic              r_op_we;
    logic [TO_W-1:0]   r_wdog;
    logic [ADDR_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_mem_data_write;
    logic              r_mem_write;
    logic              r_mem_read;
    logic              r_a_done;
    logic              r_b_done;
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;
    logic              r_timeout_err;

    // B wins only when A is silent or A held the previous grant.
    logic              w_any_req;
    logic              w_grant_b;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    assign w_any_req   = bus.a_req | bus.b_req;
    assign w_grant_b   = bus.b_req & (~bus.a_req | (r_last == PORT_A));
    assign w_sel_we    = w_grant_b ? bus.b_we    : bus.a_we;
    assign w_sel_addr  = w_grant_b ? bus.b_addr  : bus.a_addr;
    assign w_sel_wdata = w_grant_b ? bus.b_wdata : bus.a_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_owner          <= PORT_A;
            r_last           <= PORT_B;
            r_op_we          <= 1'b0;
            r_wdog           <= '0;
            r_mem_address    <= '0;
            r_mem_data_write <= '0;
            r_mem_write      <= 1'b0;
            r_mem_read       <= 1'b0;
            r_a_done         <= 1'b0;
            r_b_done         <= 1'b0;
            r_a_rdata        <= '0;
            r_b_rdata        <= '0;
            r_timeout_err    <= 1'b0;
        end else begin
            // NOTE: one-cycle pulses default low here; a later assignment in the case wins.
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_a_done    <= 1'b0;
            r_b_done    <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_any_req && bus.mem_ready) begin
                        r_owner          <= w_grant_b ? PORT_B : PORT_A;
                        r_op_we          <= w_sel_we;
                        r_mem_address    <= w_sel_addr;
                        r_mem_data_write <= w_sel_wdata;
                        r_mem_write      <= w_sel_we;
                        r_mem_read       <= ~w_sel_we;
                        r_state          <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    r_wdog  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.mem_ready) begin
                        if (!r_op_we) begin
                            if (r_owner == PORT_A) r_a_rdata <= bus.mem_data_read;
                            else                   r_b_rdata <= bus.mem_data_read;
                        end
                        r_a_done <= (r_owner == PORT_A);
                        r_b_done <= (r_owner == PORT_B);
                        r_state  <= S_RESP;
                    end else if (r_wdog == TO_LIMIT) begin
                        // Forced completion: rdata is left untouched.
                        r_timeout_err <= 1'b1;
                        r_a_done      <= (r_owner == PORT_A);
                        r_b_done      <= (r_owner == PORT_B);
                        r_state       <= S_RESP;
                    end else begin
                        r_wdog <= r_wdog + TO_W'(1);
                    end
                end
                S_RESP: begin
                    r_last  <= r_owner;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_address    = r_mem_address;
    assign bus.mem_data_write = r_mem_data_write;
    assign bus.mem_write      = r_mem_write;
    assign bus.mem_read       = r_mem_read;
    assign bus.a_done         = r_a_done;
    assign bus.b_done         = r_b_done;
    assign bus.a_rdata        = r_a_rdata;
    assign bus.b_rdata        = r_b_rdata;
    assign bus.busy           = (r_state != S_IDLE);
    assign bus.timeout_err    = r_timeout_err;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomised bench for sram_arbiter: a transaction-level model predicts grants, strobe and
// completion cycles; a separate monitor pops the expectation queues whenever the DUT acts.
module tb_sram_arbiter;
    localparam int ADDR_W  = 18;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 4;
    localparam int TO_W    = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT),
        .TO_W   (TO_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int                port;
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
        int                strobe_cyc;
        int                done_cyc;
        bit                sticky;
    } exp_t;

    typedef struct {
        bit                active;
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                lat;
        int                done_cyc;
        bit                cont;
    } req_t;

    exp_t sq[$];
    exp_t dq[$];
    req_t ports[2];

    // Reference model state.
    int                m_last;
    int                free_edge;
    int                last_grant_edge;
    bit                m_sticky;
    logic [DATA_W-1:0] m_rdata[2];
    logic [DATA_W-1:0] mem[int];
    int                busy_lo;
    int                busy_hi;
    bit                force_busy;
    logic [DATA_W-1:0] cur_rd;

    function automatic logic [DATA_W-1:0] mem_rd(input int a);
        if (mem.exists(a)) return mem[a];
        return DATA_W'(32'h1234 + a * 32'h0101);
    endfunction

    task automatic drive_ports();
        bus.a_req   = ports[0].active;
        bus.a_we    = ports[0].we;
        bus.a_addr  = ports[0].addr;
        bus.a_wdata = ports[0].wdata;
        bus.b_req   = ports[1].active;
        bus.b_we    = ports[1].we;
        bus.b_addr  = ports[1].addr;
        bus.b_wdata = ports[1].wdata;
    endtask

    task automatic post(input int p, input bit we, input int addr, input int wdata,
                        input int lat, input bit cont);
        ports[p].active   = 1'b1;
        ports[p].we       = we;
        ports[p].addr     = ADDR_W'(addr);
        ports[p].wdata    = DATA_W'(wdata);
        ports[p].lat      = lat;
        ports[p].done_cyc = -1;
        ports[p].cont     = cont;
        drive_ports();
    endtask

    // Controller response for the coming edge, then the grant decision the arbiter must take.
    task automatic predict();
        int   e;
        int   p;
        int   eff;
        bit   to;
        exp_t x;
        e = cyc + 1;
        bus.mem_ready     = !(force_busy || (cyc >= busy_lo && cyc <= busy_hi));
        bus.mem_data_read = bus.mem_ready ? cur_rd : DATA_W'($urandom);
        if (reset || e < free_edge || !bus.mem_ready) return;
        if (!ports[0].active && !ports[1].active) return;
        if (ports[0].active && ports[1].active) p = (m_last == 0) ? 1 : 0;
        else p = ports[0].active ? 0 : 1;
        to  = ports[p].lat > TIMEOUT;
        eff = to ? TIMEOUT : ports[p].lat;
        if (ports[p].we) begin
            mem[int'(ports[p].addr)] = ports[p].wdata;
            cur_rd = DATA_W'($urandom);
        end else begin
            cur_rd = mem_rd(int'(ports[p].addr));
            if (!to) m_rdata[p] = cur_rd;
        end
        m_sticky     = m_sticky | to;
        x.port       = p;
        x.we         = ports[p].we;
        x.addr       = ports[p].addr;
        x.wdata      = ports[p].wdata;
        x.rdata      = m_rdata[p];
        x.strobe_cyc = e;
        x.done_cyc   = e + 3 + eff;
        x.sticky     = m_sticky;
        ports[p].done_cyc = x.done_cyc;
        if (ports[p].lat > 0) begin
            busy_lo = e;
            busy_hi = e + 1 + ports[p].lat;
        end
        free_edge       = e + 5 + eff;
        m_last          = p;
        last_grant_edge = e;
        sq.push_back(x);
        dq.push_back(x);
    endtask

    task automatic step();
        predict();
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            if (ports[p].active && ports[p].done_cyc == cyc) begin
                if (ports[p].cont) ports[p].done_cyc = -1;
                else ports[p].active = 1'b0;
            end
        end
        drive_ports();
    endtask

    task automatic check_reset_outputs();
        check("rst_a_done",         bus.a_done,         0);
        check("rst_b_done",         bus.b_done,         0);
        check("rst_a_rdata",        bus.a_rdata,        0);
        check("rst_b_rdata",        bus.b_rdata,        0);
        check("rst_mem_write",      bus.mem_write,      0);
        check("rst_mem_read",       bus.mem_read,       0);
        check("rst_mem_address",    bus.mem_address,    0);
        check("rst_mem_data_write", bus.mem_data_write, 0);
        check("rst_busy",           bus.busy,           0);
        check("rst_timeout_err",    bus.timeout_err,    0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        sq.delete();
        dq.delete();
        for (int p = 0; p < 2; p++) begin
            ports[p].active = 1'b0;
            ports[p].cont   = 1'b0;
            m_rdata[p]      = '0;
        end
        drive_ports();
        busy_lo    = 1;
        busy_hi    = 0;
        force_busy = 1'b0;
        m_last     = 1;
        m_sticky   = 1'b0;
        repeat (n) step();
        check_reset_outputs();
        reset     = 1'b0;
        free_edge = cyc + 1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((ports[0].active || ports[1].active || dq.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check("idle_within_budget", dq.size(), 0);
        repeat (2) step();
    endtask

    // Monitor: compares every strobe and every done against the head of the queues.
    always @(negedge clk) begin : monitor
        exp_t                     x;
        static logic [DATA_W-1:0] hold[2] = '{default: '0};
        if (reset) begin
            hold[0] = '0;
            hold[1] = '0;
        end else begin
            if (bus.mem_write || bus.mem_read) begin
                check("strobe_exclusive", bus.mem_write & bus.mem_read, 0);
                if (sq.size() == 0) begin
                    check("unexpected_strobe", {bus.mem_write, bus.mem_read}, 0);
                end else begin
                    x = sq.pop_front();
                    check("strobe_cycle", cyc, x.strobe_cyc);
                    check("strobe_we",    bus.mem_write, x.we);
                    check("strobe_addr",  bus.mem_address, x.addr);
                    check("strobe_wdata", bus.mem_data_write, x.wdata);
                    check("busy_in_issue", bus.busy, 1);
                end
            end else if (sq.size() != 0 && sq[0].strobe_cyc < cyc) begin
                check("strobe_missing_at", cyc, sq[0].strobe_cyc);
                void'(sq.pop_front());
            end

            if (bus.a_done || bus.b_done) begin
                check("done_exclusive", bus.a_done & bus.b_done, 0);
                if (dq.size() == 0) begin
                    check("unexpected_done", {bus.a_done, bus.b_done}, 0);
                end else begin
                    x = dq.pop_front();
                    check("done_cycle",  cyc, x.done_cyc);
                    check("done_port",   bus.b_done, x.port);
                    check("done_rdata",  (x.port == 0) ? bus.a_rdata : bus.b_rdata, x.rdata);
                    check("timeout_err", bus.timeout_err, x.sticky);
                    check("addr_held",   bus.mem_address, x.addr);
                    hold[x.port] = x.rdata;
                end
            end else if (dq.size() != 0 && dq[0].done_cyc < cyc) begin
                check("done_missing_at", cyc, dq[0].done_cyc);
                void'(dq.pop_front());
            end

            check("a_rdata_hold", bus.a_rdata, hold[0]);
            check("b_rdata_hold", bus.b_rdata, hold[1]);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        int r;
        int lat;
        reset  = 1'b1;
        cur_rd = '0;
        for (int p = 0; p < 2; p++) begin
            ports[p] = '{active: 1'b0, we: 1'b0, addr: '0, wdata: '0, lat: 0, done_cyc: -1, cont: 1'b0};
        end
        drive_ports();
        bus.mem_ready     = 1'b1;
        bus.mem_data_read = '0;
        do_reset(3);

        // Single write with controller always ready.
        post(0, 1'b1, 'h10, 'hAAAA, 0, 1'b0);
        wait_idle(50);

        // Read back with three busy WAIT cycles.
        post(0, 1'b0, 'h10, 'h5555, 3, 1'b0);
        wait_idle(50);

        // Both ports requesting continuously: strict alternation.
        post(0, 1'b1, 'h1, 'h1111, 0, 1'b1);
        post(1, 1'b0, 'h2, 'h2222, 0, 1'b1);
        repeat (32) step();
        ports[0].cont = 1'b0;
        ports[1].cont = 1'b0;
        wait_idle(50);

        // Controller never answers a B read: watchdog forces completion.
        post(1, 1'b0, 'h2, 'h0, 20, 1'b0);
        wait_idle(80);
        post(0, 1'b1, 'h3, 'hBEEF, 0, 1'b0);
        post(1, 1'b0, 'h3, 'h0, 1, 1'b0);
        wait_idle(80);

        // Reset in the middle of an A read's WAIT phase.
        post(0, 1'b0, 'h4, 'h0, 10, 1'b0);
        r = 0;
        while (cyc < last_grant_edge + 3 && r < 20) begin
            step();
            r++;
        end
        do_reset(2);
        repeat (4) step();
        post(0, 1'b1, 'h5, 'hCAFE, 0, 1'b0);
        post(1, 1'b1, 'h6, 'hF00D, 0, 1'b0);
        wait_idle(50);

        // Controller not ready while A requests: no strobe until ready rises.
        force_busy = 1'b1;
        post(0, 1'b0, 'h5, 'h0, 0, 1'b0);
        repeat (5) step();
        check("busy_while_not_ready", bus.busy, 0);
        force_busy = 1'b0;
        wait_idle(50);

        // Random traffic, occasional watchdog expiry.
        repeat (500) begin
            for (int p = 0; p < 2; p++) begin
                if (!ports[p].active && $urandom_range(0, 2) == 0) begin
                    r = int'($urandom_range(0, 9));
                    lat = (r < 4) ? 0 : (r < 8) ? r - 3 : TIMEOUT + 2;
                    post(p, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                         int'($urandom_range(0, 65535)), lat, 1'b0);
                end
            end
            step();
        end
        wait_idle(200);

        check("strobe_queue_drained", sq.size(), 0);
        check("done_queue_drained",   dq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
